// File: rtl/avalon_st_mult_link_if.sv
// Bundle for the multiply link: the operand/result pair seen by the
// surrounding logic, plus read-only copies of the two internal byte-wide
// Avalon-ST channels so a stream monitor can observe framing and beat counts.
// The "slave" modport is the link itself; the "master" modport is the
// operand source / result consumer and channel observer.
interface avalon_st_mult_link_if #(
  parameter int SZ  = 32,
  parameter int DSZ = 8
);
  // Operands and result
  logic [SZ-1:0]   A;
  logic [SZ-1:0]   B;
  logic [2*SZ-1:0] RES;
  logic            ready_res;

  // Request channel copy (operands travelling towards the multiplier)
  logic [DSZ-1:0]  req_data;
  logic            req_valid;
  logic            req_ready;
  logic            req_sop;
  logic            req_eop;

  // Response channel copy (product travelling back)
  logic [DSZ-1:0]  rsp_data;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_sop;
  logic            rsp_eop;

  modport master (
    output A, B,
    input  RES, ready_res,
    input  req_data, req_valid, req_ready, req_sop, req_eop,
    input  rsp_data, rsp_valid, rsp_ready, rsp_sop, rsp_eop
  );

  modport slave (
    input  A, B,
    output RES, ready_res,
    output req_data, req_valid, req_ready, req_sop, req_eop,
    output rsp_data, rsp_valid, rsp_ready, rsp_sop, rsp_eop
  );
endinterface

// File: rtl/avalon_st_mult_link.sv
// Self-contained multiply link. The request side captures {B,A}, sends it
// LSB-first as one byte-wide Avalon-ST packet, waits for the product packet
// and publishes it on RES with a one-cycle ready_res pulse. The response side
// reassembles the operands, multiplies them (full width, unsigned) and
// streams the product back. Both receivers apply the same framing rules:
// SOP restarts a packet, beats before any SOP are dropped, beats beyond the
// expected count are dropped, and EOP at the wrong index discards the packet.
module avalon_st_mult_link #(
  parameter int SZ  = 32,
  parameter int DSZ = 8
) (
  input  logic                  clk,
  input  logic                  _rst,
  avalon_st_mult_link_if.slave  bus
);

  localparam int NREQ = (2 * SZ) / DSZ;
  localparam int NRSP = (2 * SZ) / DSZ;
  localparam int IW   = $clog2(NREQ + 1);

  typedef enum logic [1:0] {
    M_IDLE,
    M_SEND,
    M_WAIT,
    M_DONE
  } m_state_e;

  typedef enum logic [1:0] {
    S_RECV,
    S_CALC,
    S_SEND
  } s_state_e;

  // Outcome of presenting one accepted beat to a packet receiver.
  typedef struct packed {
    logic [IW-1:0] idx;     // index the next non-SOP beat will land on
    logic [IW-1:0] wr_idx;  // byte slot written by this beat
    logic          in_pkt;  // receiver is inside a packet after this beat
    logic          wr;      // this beat carries a byte to store
    logic          done;    // this beat completed a well-formed packet
  } rx_step_t;

  // Shared framing rules for both receivers; last is the index of the final
  // expected beat.
  function automatic rx_step_t rx_step(input logic [IW-1:0] idx,
                                       input logic          in_pkt,
                                       input logic          sop,
                                       input logic          eop,
                                       input logic [IW-1:0] last);
    rx_step_t r;
    r.idx    = idx;
    r.wr_idx = idx;
    r.in_pkt = in_pkt;
    r.wr     = 1'b0;
    r.done   = 1'b0;
    if (sop) begin
      r.wr     = 1'b1;
      r.wr_idx = '0;
      if (eop) begin
        r.in_pkt = 1'b0;
        r.done   = (last == '0);
      end else begin
        r.in_pkt = 1'b1;
        r.idx    = IW'(1);
      end
    end else if (in_pkt) begin
      if (idx > last) begin
        // Overflowing beats are dropped; a late EOP ends the broken packet.
        if (eop) begin
          r.in_pkt = 1'b0;
        end
      end else begin
        r.wr = 1'b1;
        if (eop) begin
          r.in_pkt = 1'b0;
          r.done   = (idx == last);
        end else begin
          r.idx = idx + IW'(1);
        end
      end
    end
    return r;
  endfunction

  // Request side state
  m_state_e        m_state_q, m_state_d;
  logic [2*SZ-1:0] shreg_q, shreg_d;
  logic [IW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2*SZ-1:0] racc_q, racc_d;
  logic [IW-1:0]   ridx_q, ridx_d;
  logic            rin_pkt_q, rin_pkt_d;
  logic [2*SZ-1:0] res_q, res_d;
  logic            ready_res_q, ready_res_d;
  rx_step_t        m_rx;

  // Response side state
  s_state_e        s_state_q, s_state_d;
  logic [2*SZ-1:0] buf_q, buf_d;
  logic [IW-1:0]   sidx_q, sidx_d;
  logic            sin_pkt_q, sin_pkt_d;
  logic [2*SZ-1:0] prod_q, prod_d;
  logic [IW-1:0]   stx_q, stx_d;
  logic            s_ready_q, s_ready_d;
  rx_step_t        s_rx;

  // Internal Avalon-ST channels
  logic [DSZ-1:0]  req_data;
  logic            req_valid;
  logic            req_ready;
  logic            req_sop;
  logic            req_eop;
  logic [DSZ-1:0]  rsp_data;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_sop;
  logic            rsp_eop;

  // Channel signals come straight from registers so neither side has a
  // combinational path through the other.
  assign req_valid = (m_state_q == M_SEND);
  assign req_data  = shreg_q[DSZ-1:0];
  assign req_sop   = req_valid && (tx_cnt_q == '0);
  assign req_eop   = req_valid && (tx_cnt_q == IW'(NREQ - 1));
  assign req_ready = s_ready_q;

  assign rsp_valid = (s_state_q == S_SEND);
  assign rsp_data  = prod_q[DSZ-1:0];
  assign rsp_sop   = rsp_valid && (stx_q == '0);
  assign rsp_eop   = rsp_valid && (stx_q == IW'(NRSP - 1));
  assign rsp_ready = (m_state_q == M_WAIT);

  assign bus.RES       = res_q;
  assign bus.ready_res = ready_res_q;
  assign bus.req_data  = req_data;
  assign bus.req_valid = req_valid;
  assign bus.req_ready = req_ready;
  assign bus.req_sop   = req_sop;
  assign bus.req_eop   = req_eop;
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_ready = rsp_ready;
  assign bus.rsp_sop   = rsp_sop;
  assign bus.rsp_eop   = rsp_eop;

  // Request side: capture, serialise, collect the product, publish it.
  always_comb begin
    m_state_d   = m_state_q;
    shreg_d     = shreg_q;
    tx_cnt_d    = tx_cnt_q;
    racc_d      = racc_q;
    ridx_d      = ridx_q;
    rin_pkt_d   = rin_pkt_q;
    res_d       = res_q;
    ready_res_d = 1'b0;
    m_rx        = '0;
    case (m_state_q)
      M_IDLE: begin
        shreg_d   = {bus.B, bus.A};
        tx_cnt_d  = '0;
        m_state_d = M_SEND;
      end
      M_SEND: begin
        if (req_ready) begin
          shreg_d  = shreg_q >> DSZ;
          tx_cnt_d = tx_cnt_q + IW'(1);
          if (req_eop) begin
            ridx_d    = '0;
            rin_pkt_d = 1'b0;
            m_state_d = M_WAIT;
          end
        end
      end
      M_WAIT: begin
        if (rsp_valid) begin
          m_rx      = rx_step(ridx_q, rin_pkt_q, rsp_sop, rsp_eop, IW'(NRSP - 1));
          ridx_d    = m_rx.idx;
          rin_pkt_d = m_rx.in_pkt;
          for (int i = 0; i < NRSP; i++) begin
            if (m_rx.wr && (m_rx.wr_idx == IW'(i))) begin
              racc_d[i*DSZ +: DSZ] = rsp_data;
            end
          end
          if (m_rx.done) begin
            m_state_d = M_DONE;
          end
        end
      end
      M_DONE: begin
        res_d       = racc_q;
        ready_res_d = 1'b1;
        rin_pkt_d   = 1'b0;
        m_state_d   = M_IDLE;
      end
      default: begin
        m_state_d = M_IDLE;
      end
    endcase
  end

  // Request side registers.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      m_state_q   <= M_IDLE;
      shreg_q     <= '0;
      tx_cnt_q    <= '0;
      racc_q      <= '0;
      ridx_q      <= '0;
      rin_pkt_q   <= 1'b0;
      res_q       <= '0;
      ready_res_q <= 1'b0;
    end else begin
      m_state_q   <= m_state_d;
      shreg_q     <= shreg_d;
      tx_cnt_q    <= tx_cnt_d;
      racc_q      <= racc_d;
      ridx_q      <= ridx_d;
      rin_pkt_q   <= rin_pkt_d;
      res_q       <= res_d;
      ready_res_q <= ready_res_d;
    end
  end

  // Response side: reassemble operands, multiply once, stream the product.
  always_comb begin
    s_state_d = s_state_q;
    buf_d     = buf_q;
    sidx_d    = sidx_q;
    sin_pkt_d = sin_pkt_q;
    prod_d    = prod_q;
    stx_d     = stx_q;
    s_rx      = '0;
    case (s_state_q)
      S_RECV: begin
        if (req_valid && req_ready) begin
          s_rx      = rx_step(sidx_q, sin_pkt_q, req_sop, req_eop, IW'(NREQ - 1));
          sidx_d    = s_rx.idx;
          sin_pkt_d = s_rx.in_pkt;
          for (int i = 0; i < NREQ; i++) begin
            if (s_rx.wr && (s_rx.wr_idx == IW'(i))) begin
              buf_d[i*DSZ +: DSZ] = req_data;
            end
          end
          if (s_rx.done) begin
            s_state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        prod_d    = (2*SZ)'(buf_q[SZ-1:0]) * (2*SZ)'(buf_q[2*SZ-1:SZ]);
        stx_d     = '0;
        s_state_d = S_SEND;
      end
      S_SEND: begin
        if (rsp_ready) begin
          prod_d = prod_q >> DSZ;
          stx_d  = stx_q + IW'(1);
          if (rsp_eop) begin
            sidx_d    = '0;
            sin_pkt_d = 1'b0;
            s_state_d = S_RECV;
          end
        end
      end
      default: begin
        s_state_d = S_RECV;
      end
    endcase
    // Ready is registered so it stays low for the whole reset period.
    s_ready_d = (s_state_d == S_RECV);
  end

  // Response side registers.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      s_state_q <= S_RECV;
      buf_q     <= '0;
      sidx_q    <= '0;
      sin_pkt_q <= 1'b0;
      prod_q    <= '0;
      stx_q     <= '0;
      s_ready_q <= 1'b0;
    end else begin
      s_state_q <= s_state_d;
      buf_q     <= buf_d;
      sidx_q    <= sidx_d;
      sin_pkt_q <= sin_pkt_d;
      prod_q    <= prod_d;
      stx_q     <= stx_d;
      s_ready_q <= s_ready_d;
    end
  end

endmodule

// File: tb/tb_avalon_st_mult_link.sv
// Bench for avalon_st_mult_link. A timing model predicts RES/ready_res from
// the loop structure (capture, 8 request beats, multiply, 8 response beats,
// publish) and plain multiplication; a stream monitor checks packet framing
// and the payload of every request and response packet.
module tb_avalon_st_mult_link;

  localparam int LOOP = 1 + 8 + 1 + 8 + 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  avalon_st_mult_link_if #(.SZ(32), .DSZ(8)) bus ();

  avalon_st_mult_link dut (
    .clk  (clk),
    ._rst (rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state
  int          cyc_k;
  logic [63:0] held_prod;
  logic [63:0] exp_res;
  logic        exp_rdy;
  logic [63:0] req_exp_q[$];
  logic [63:0] rsp_exp_q[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    bus.A = a;
    bus.B = b;
  endtask

  // Wait (bounded) for the next visible ready_res pulse, counting falling edges.
  task automatic waitPulse(input string name, input int bound, output int cycles);
    bit found;
    found  = 1'b0;
    cycles = 0;
    while (!found && cycles < bound) begin
      @(negedge clk);
      cycles++;
      if (bus.ready_res === 1'b1) found = 1'b1;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s timeout actual=no_pulse expected=pulse within %0d cycles", name, bound);
    end
  endtask

  // Timing model: loop position counted from the first edge after reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_k     = 0;
      exp_res   = '0;
      exp_rdy   = 1'b0;
      held_prod = '0;
      req_exp_q.delete();
      rsp_exp_q.delete();
    end else begin
      exp_rdy = ((cyc_k % LOOP) == LOOP - 1);
      if (exp_rdy) exp_res = held_prod;
      if ((cyc_k % LOOP) == 0) begin
        held_prod = 64'(bus.A) * 64'(bus.B);
        req_exp_q.push_back({bus.B, bus.A});
        rsp_exp_q.push_back(held_prod);
      end
      cyc_k++;
    end
  end

  // Compare process: outputs against the model on every cycle.
  always @(negedge clk) begin
    checkOutput("res_model", bus.RES, exp_res);
    checkOutput("ready_res_model", 64'(bus.ready_res), 64'(exp_rdy));
    if (!rst_n) begin
      checkOutput("reset_stream_idle",
                  64'({bus.req_valid, bus.req_sop, bus.req_eop, bus.req_ready,
                       bus.rsp_valid, bus.rsp_sop, bus.rsp_eop}), 64'd0);
    end
  end

  // Stream monitor: beats observed where valid && ready will transfer.
  int          req_beat;
  int          rsp_beat;
  logic [63:0] req_acc;
  logic [63:0] rsp_acc;
  logic [63:0] exp_pkt;

  always @(negedge clk) begin
    if (!rst_n) begin
      req_beat = 0;
      rsp_beat = 0;
      req_acc  = '0;
      rsp_acc  = '0;
    end else begin
      if (bus.req_valid && bus.req_ready) begin
        checkOutput("req_sop", 64'(bus.req_sop), 64'(req_beat == 0));
        checkOutput("req_eop", 64'(bus.req_eop), 64'(req_beat == 7));
        if (req_beat < 8) req_acc[req_beat*8 +: 8] = bus.req_data;
        if (bus.req_eop) begin
          checkOutput("req_beat_count", 64'(req_beat + 1), 64'd8);
          if (req_exp_q.size() == 0) begin
            checkOutput("req_payload_expected", 64'd0, 64'd1);
          end else begin
            exp_pkt = req_exp_q.pop_front();
            checkOutput("req_payload", req_acc, exp_pkt);
          end
          req_beat = 0;
        end else begin
          req_beat++;
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        checkOutput("rsp_sop", 64'(bus.rsp_sop), 64'(rsp_beat == 0));
        checkOutput("rsp_eop", 64'(bus.rsp_eop), 64'(rsp_beat == 7));
        if (rsp_beat < 8) rsp_acc[rsp_beat*8 +: 8] = bus.rsp_data;
        if (bus.rsp_eop) begin
          checkOutput("rsp_beat_count", 64'(rsp_beat + 1), 64'd8);
          if (rsp_exp_q.size() == 0) begin
            checkOutput("rsp_payload_expected", 64'd0, 64'd1);
          end else begin
            exp_pkt = rsp_exp_q.pop_front();
            checkOutput("rsp_payload", rsp_acc, exp_pkt);
          end
          rsp_beat = 0;
        end else begin
          rsp_beat++;
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=still_running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence with randomized operand rounds.
  initial begin
    int cyc;
    int waited;
    logic [31:0] ra;
    logic [31:0] rb;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    applyStimulus(32'd0, 32'd0);

    // Reset held for four cycles.
    repeat (4) @(negedge clk);
    checkOutput("reset_res", bus.RES, 64'd0);
    checkOutput("reset_ready_res", 64'(bus.ready_res), 64'd0);

    // First product and its latency from the release.
    applyStimulus(32'd10234, 32'd566);
    rst_n = 1'b1;
    waitPulse("first_pulse", 40, cyc);
    checkOutput("first_latency", 64'(cyc), 64'd19);
    checkOutput("first_res", bus.RES, 64'd5792444);

    // Operand change mid-loop: next result still old, the one after new.
    repeat (5) @(negedge clk);
    applyStimulus(32'd32, 32'd12);
    waitPulse("change_old_pulse", 40, cyc);
    checkOutput("change_old_res", bus.RES, 64'd5792444);
    waitPulse("change_new_pulse", 40, cyc);
    checkOutput("change_new_res", bus.RES, 64'd384);

    // Randomized rounds, including zero operands.
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) ra = 32'd0;
      if (i == 1) rb = 32'd0;
      applyStimulus(ra, rb);
      waitPulse("rand_pulse", 40, cyc);
      checkOutput("rand_res", bus.RES, 64'(ra) * 64'(rb));
    end

    // Maximum operands, then steady-state period with constant inputs.
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitPulse("max_pulse", 40, cyc);
    checkOutput("max_res", bus.RES, 64'hFFFF_FFFE_0000_0001);
    for (int i = 0; i < 3; i++) begin
      waitPulse("period_pulse", 40, cyc);
      checkOutput("period_cycles", 64'(cyc), 64'd19);
      checkOutput("period_res", bus.RES, 64'hFFFF_FFFE_0000_0001);
    end

    // Asynchronous reset while the product is streaming back.
    waited = 0;
    while (bus.rsp_valid !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("rsp_seen_before_reset", 64'(bus.rsp_valid), 64'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_res", bus.RES, 64'd0);
    checkOutput("async_reset_ready_res", 64'(bus.ready_res), 64'd0);
    repeat (3) @(negedge clk);
    applyStimulus(32'd10234, 32'd566);
    rst_n = 1'b1;
    waitPulse("post_reset_pulse", 40, cyc);
    checkOutput("post_reset_latency", 64'(cyc), 64'd19);
    checkOutput("post_reset_res", bus.RES, 64'd5792444);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
